// File: rtl/apb_periph_demux_pkg.sv
// Shared types and helpers for the APB peripheral demux.
package apb_periph_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DSETUP,
        DACCESS,
        RESP
    } state_e;

    function automatic int unsigned idx_width(int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_periph_demux_if.sv
// Upstream APB3 bus between the bridge and the demux.
interface apb_periph_demux_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();

    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pwrite;
    logic          psel;
    logic          penable;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    modport master (
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_periph_demux_addr_decode.sv
// Region decoder: inclusive start/end compare, lowest port wins.
module apb_addr_decode
    import apb_periph_pkg::*;
#(
    parameter int unsigned NB_MASTER = 11,
    parameter int unsigned AW        = 32,
    localparam int unsigned IW       = idx_width(NB_MASTER)
) (
    input  logic [AW-1:0]                paddr,
    input  logic [NB_MASTER-1:0][AW-1:0] start_addr,
    input  logic [NB_MASTER-1:0][AW-1:0] end_addr,
    output logic                         hit,
    output logic [IW-1:0]                idx
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        // Walk downwards so the lowest matching index is written last.
        for (int i = int'(NB_MASTER) - 1; i >= 0; i--) begin
            if (paddr >= start_addr[i] && paddr <= end_addr[i]) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/apb_periph_demux.sv
// APB3 demux: decode, re-timed downstream transfer, miss/timeout errors.
module apb_periph_demux
    import apb_periph_pkg::*;
#(
    parameter int unsigned NB_MASTER      = 11,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    apb_periph_demux_if.slave                        s,
    output logic [APB_ADDR_WIDTH-1:0]                m_paddr_o,
    output logic [APB_DATA_WIDTH-1:0]                m_pwdata_o,
    output logic                                     m_pwrite_o,
    output logic [NB_MASTER-1:0]                     m_psel_o,
    output logic                                     m_penable_o,
    input  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0] m_prdata_i,
    input  logic [NB_MASTER-1:0]                     m_pready_i,
    input  logic [NB_MASTER-1:0]                     m_pslverr_i,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] end_addr_i,
    output logic                                     err_valid_o,
    output logic [APB_ADDR_WIDTH-1:0]                err_addr_o,
    output logic                                     err_timeout_o,
    input  logic                                     err_clr_i
);

    localparam int unsigned IW = idx_width(NB_MASTER);
    localparam int unsigned TW =
        (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [APB_DATA_WIDTH-1:0] ERR_D = APB_DATA_WIDTH'(ERR_RDATA);

    state_e                    state;
    logic [IW-1:0]             idx_q;
    logic [TW-1:0]             tcnt;
    logic                      pready_q;
    logic                      pslverr_q;
    logic [APB_DATA_WIDTH-1:0] prdata_q;
    logic                      dec_hit;
    logic [IW-1:0]             dec_idx;
    logic                      sel_ready;
    logic                      sel_err;
    logic [APB_DATA_WIDTH-1:0] sel_rdata;
    logic                      tmo;

    apb_addr_decode #(
        .NB_MASTER (NB_MASTER),
        .AW        (APB_ADDR_WIDTH)
    ) u_dec (
        .paddr      (s.paddr),
        .start_addr (start_addr_i),
        .end_addr   (end_addr_i),
        .hit        (dec_hit),
        .idx        (dec_idx)
    );

    assign sel_ready = m_pready_i[idx_q];
    assign sel_err   = m_pslverr_i[idx_q];
    assign sel_rdata = m_prdata_i[idx_q];
    assign tmo = (TIMEOUT_CYCLES != 0) &&
                 (tcnt == TW'(TIMEOUT_CYCLES - 1));

    assign s.prdata  = prdata_q;
    assign s.pready  = pready_q;
    assign s.pslverr = pslverr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            idx_q         <= '0;
            tcnt          <= '0;
            pready_q      <= 1'b0;
            pslverr_q     <= 1'b0;
            prdata_q      <= '0;
            m_paddr_o     <= '0;
            m_pwdata_o    <= '0;
            m_pwrite_o    <= 1'b0;
            m_psel_o      <= '0;
            m_penable_o   <= 1'b0;
            err_valid_o   <= 1'b0;
            err_addr_o    <= '0;
            err_timeout_o <= 1'b0;
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            if (err_clr_i) err_valid_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (s.psel && !s.penable) begin
                        m_paddr_o  <= s.paddr;
                        m_pwdata_o <= s.pwdata;
                        m_pwrite_o <= s.pwrite;
                        idx_q      <= dec_idx;
                        tcnt       <= '0;
                        if (dec_hit) begin
                            m_psel_o <= NB_MASTER'(1) << dec_idx;
                            state    <= DSETUP;
                        end else begin
                            pready_q      <= 1'b1;
                            pslverr_q     <= 1'b1;
                            prdata_q      <= ERR_D;
                            err_valid_o   <= 1'b1;
                            err_addr_o    <= s.paddr;
                            err_timeout_o <= 1'b0;
                            state         <= RESP;
                        end
                    end
                end
                DSETUP: begin
                    m_penable_o <= 1'b1;
                    tcnt        <= '0;
                    state       <= DACCESS;
                end
                DACCESS: begin
                    if (sel_ready || tmo) begin
                        m_psel_o    <= '0;
                        m_penable_o <= 1'b0;
                        state       <= IDLE;
                        // A master that dropped psel gets no response.
                        if (s.psel) begin
                            state    <= RESP;
                            pready_q <= 1'b1;
                            if (sel_ready) begin
                                pslverr_q <= sel_err;
                                prdata_q  <= sel_err    ? ERR_D :
                                             m_pwrite_o ? '0    : sel_rdata;
                            end else begin
                                pslverr_q     <= 1'b1;
                                prdata_q      <= ERR_D;
                                err_valid_o   <= 1'b1;
                                err_addr_o    <= m_paddr_o;
                                err_timeout_o <= 1'b1;
                            end
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_periph_demux.sv
// Directed bench for apb_periph_demux with a wait-state peripheral model.
module tb_apb_periph_demux;

    localparam int NB = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_periph_demux_if #(.AW(32), .DW(32)) bus ();

    logic [31:0]          m_paddr;
    logic [31:0]          m_pwdata;
    logic                 m_pwrite;
    logic [NB-1:0]        m_psel;
    logic                 m_penable;
    logic [NB-1:0][31:0]  m_prdata;
    logic [NB-1:0]        m_pready;
    logic [NB-1:0]        m_pslverr;
    logic [NB-1:0][31:0]  st;
    logic [NB-1:0][31:0]  en;
    logic                 err_valid;
    logic [31:0]          err_addr;
    logic                 err_timeout;
    logic                 err_clr = 1'b0;

    int wait_st [NB];
    int acc = 0;
    int n_vec = 0;
    int n_err = 0;

    apb_periph_demux #(
        .NB_MASTER      (NB),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .s             (bus),
        .m_paddr_o     (m_paddr),
        .m_pwdata_o    (m_pwdata),
        .m_pwrite_o    (m_pwrite),
        .m_psel_o      (m_psel),
        .m_penable_o   (m_penable),
        .m_prdata_i    (m_prdata),
        .m_pready_i    (m_pready),
        .m_pslverr_i   (m_pslverr),
        .start_addr_i  (st),
        .end_addr_i    (en),
        .err_valid_o   (err_valid),
        .err_addr_o    (err_addr),
        .err_timeout_o (err_timeout),
        .err_clr_i     (err_clr)
    );

    // Peripherals: port p becomes ready after wait_st[p] ACCESS cycles.
    always_comb begin
        m_pready = '0;
        m_prdata = '0;
        for (int p = 0; p < NB; p++) begin
            m_pready[p] = m_penable && (acc >= wait_st[p]);
            m_prdata[p] = (p == 9) ? 32'h1234_5678 : 32'h1000_0000 + p;
        end
    end

    always @(posedge clk) begin
        if (!m_penable || |(m_pready & m_psel)) acc <= 0;
        else acc <= acc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_map();
        for (int p = 0; p < NB; p++) begin
            st[p] = 32'h1A0F_F000 + p * 32'h1000;
            en[p] = st[p] + 32'hFFF;
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic w,
                        input logic [31:0] wd, input int drop_at,
                        output int lat, output logic [31:0] rd,
                        output logic er, output logic [NB-1:0] sor,
                        output int scnt);
        @(negedge clk);
        bus.paddr   = a;
        bus.pwdata  = wd;
        bus.pwrite  = w;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        lat = -1; rd = '0; er = 1'b0; sor = '0; scnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            sor |= m_psel;
            if (m_psel != '0) scnt++;
            if (bus.pready) begin
                lat = k;
                rd  = bus.prdata;
                er  = bus.pslverr;
                break;
            end
            if (k == drop_at) bus.psel = 1'b0;
            bus.penable = bus.psel;
        end
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    int            lat;
    logic [31:0]   rd;
    logic          er;
    logic [NB-1:0] sor;
    int            scnt;

    initial begin
        bus.paddr = '0; bus.pwdata = '0; bus.pwrite = 1'b0;
        bus.psel = 1'b0; bus.penable = 1'b0;
        m_pslverr = '0;
        for (int p = 0; p < NB; p++) wait_st[p] = 0;
        wait_st[9] = 4;
        wait_st[3] = 1000;
        set_map();

        repeat (3) @(negedge clk);
        chk("rst_pready", bus.pready, 0);
        chk("rst_prdata", bus.prdata, 0);
        chk("rst_psel", m_psel, 0);
        chk("rst_err_valid", err_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_penable", m_penable, 0);
        chk("idle_err_addr", err_addr, 0);

        xfer(32'h1A10_0004, 1'b1, 32'hCAFE_F00D, 0, lat, rd, er, sor, scnt);
        chk("wr_lat", lat, 3);
        chk("wr_psel", sor, 11'h002);
        chk("wr_psel_cycles", scnt, 2);
        chk("wr_slverr", er, 0);
        chk("wr_prdata", rd, 0);
        chk("wr_paddr", m_paddr, 32'h1A10_0004);
        chk("wr_pwdata", m_pwdata, 32'hCAFE_F00D);
        chk("wr_pwrite", m_pwrite, 1);

        xfer(32'h1A10_8010, 1'b0, 0, 0, lat, rd, er, sor, scnt);
        chk("p9_lat", lat, 7);
        chk("p9_rdata", rd, 32'h1234_5678);
        chk("p9_psel", sor, 11'h200);

        xfer(32'h1A30_0000, 1'b0, 0, 0, lat, rd, er, sor, scnt);
        chk("miss_lat", lat, 1);
        chk("miss_slverr", er, 1);
        chk("miss_rdata", rd, 32'hDEAD_BEEF);
        chk("miss_psel", sor, 0);
        @(negedge clk);
        chk("miss_err_valid", err_valid, 1);
        chk("miss_err_addr", err_addr, 32'h1A30_0000);
        chk("miss_err_tmo", err_timeout, 0);
        chk("resp_one_cycle", bus.pready, 0);

        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_err_valid", err_valid, 0);

        xfer(32'h1A10_2000, 1'b0, 0, 0, lat, rd, er, sor, scnt);
        chk("tmo_lat", lat, 10);
        chk("tmo_slverr", er, 1);
        chk("tmo_rdata", rd, 32'hDEAD_BEEF);
        chk("tmo_psel_cycles", scnt, 9);
        chk("tmo_err_tmo", err_timeout, 1);
        chk("tmo_err_addr", err_addr, 32'h1A10_2000);
        chk("tmo_err_valid", err_valid, 1);

        xfer(32'h1A0F_F008, 1'b0, 0, 0, lat, rd, er, sor, scnt);
        chk("p0_lat", lat, 3);
        chk("p0_rdata", rd, 32'h1000_0000);
        chk("p0_slverr", er, 0);

        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_pslverr = 11'h020;
        xfer(32'h1A10_4000, 1'b0, 0, 0, lat, rd, er, sor, scnt);
        m_pslverr = '0;
        chk("fwd_slverr", er, 1);
        chk("fwd_no_err_valid", err_valid, 0);

        xfer(32'h1A10_0FFF, 1'b0, 0, 0, lat, rd, er, sor, scnt);
        chk("end_incl_psel", sor, 11'h002);
        xfer(32'h1A10_1000, 1'b0, 0, 0, lat, rd, er, sor, scnt);
        chk("start_incl_psel", sor, 11'h004);
        chk("b2b_lat", lat, 3);

        st[2] = 32'h0;   en[2] = 32'h1FF;
        st[4] = 32'h100; en[4] = 32'h2FF;
        xfer(32'h0000_0100, 1'b0, 0, 0, lat, rd, er, sor, scnt);
        chk("overlap_psel", sor, 11'h004);
        set_map();

        xfer(32'h1A10_8000, 1'b0, 0, 2, lat, rd, er, sor, scnt);
        chk("drop_no_resp", lat, -1);
        chk("drop_down_done", m_psel, 0);
        xfer(32'h1A10_0008, 1'b0, 0, 0, lat, rd, er, sor, scnt);
        chk("after_drop_lat", lat, 3);
        chk("after_drop_rdata", rd, 32'h1000_0001);

        xfer(32'h1A30_0000, 1'b0, 0, 0, lat, rd, er, sor, scnt);
        @(negedge clk);
        bus.paddr = 32'h1A10_8000; bus.pwrite = 1'b0;
        bus.psel = 1'b1; bus.penable = 1'b0;
        @(negedge clk);
        bus.penable = 1'b1;
        repeat (2) @(negedge clk);
        chk("pre_rst_penable", m_penable, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_psel", m_psel, 0);
        chk("arst_penable", m_penable, 0);
        chk("arst_err_valid", err_valid, 0);
        chk("arst_paddr", m_paddr, 0);
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(32'h1A10_0010, 1'b0, 0, 0, lat, rd, er, sor, scnt);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_rdata", rd, 32'h1000_0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
